mp_add_seq: RTL and testbench

MP_ADD_SEQ -- requirements
Module: mp_add_seq

---
 rtl/mp_add_pkg.sv | 14 +
 rtl/cla4_unit.sv | 33 +++
 rtl/mp_add_seq.sv | 125 ++++++++++++
 tb/tb_mp_add_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types for the nibble-serial multi-precision adder.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the controller state encoding and the digit width.
package mp_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_unit.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Latency: 0 cycles. Backpressure: none.
// Carries come from generate/propagate terms rather than a ripple chain.
module cla4_unit
    import mp_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision adder: one 4-bit CLA reused over NIBBLES cycles.
// Latency: done pulses NIBBLES+2 cycles after start is accepted.
// Backpressure: start is ignored while busy; optional subtract under MPADD_SUB_EN.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   c_in,
    input  logic                   sub,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out,
    output logic                   ovf
);

    localparam int IDX_W = $clog2(NIBBLES);

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0]              idx;
    logic                          carry;
    logic [NIBBLES-1:0][NIB_W-1:0] a_q;
    logic [NIBBLES-1:0][NIB_W-1:0] b_q;
    logic [NIBBLES-1:0][NIB_W-1:0] sum_q;
    logic                          c_out_q;
    logic                          ovf_q;
    logic                          done_q;

    logic                          sub_eff;
    logic [4*NIBBLES-1:0]          b_eff;
    logic                          cin_eff;
    logic                          accept;
    logic                          last_nib;
    logic [NIB_W-1:0]              cla_s;
    logic                          cla_co;

`ifdef MPADD_SUB_EN
    assign sub_eff = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
`endif

    // Subtract is A + ~B + 1; c_in has no meaning in that mode.
    assign b_eff   = sub_eff ? ~b : b;
    assign cin_eff = sub_eff ? 1'b1 : c_in;

    assign accept   = (state == ST_IDLE) && start;
    assign last_nib = (idx == IDX_W'(NIBBLES - 1));

    cla4_unit u_cla (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry),
        .s    (cla_s),
        .cout (cla_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_nib) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            carry   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // done is registered off the DONE state, so it lands in the following IDLE cycle.
            done_q <= (state == ST_DONE);
            if (accept) begin
                a_q   <= a;
                b_q   <= b_eff;
                carry <= cin_eff;
                idx   <= '0;
            end else if (state == ST_RUN) begin
                sum_q[idx] <= cla_s;
                carry      <= cla_co;
                if (last_nib) begin
                    idx     <= '0;
                    c_out_q <= cla_co;
                    ovf_q   <= (a_q[NIBBLES-1][NIB_W-1] == b_q[NIBBLES-1][NIB_W-1])
                            && (cla_s[NIB_W-1] != a_q[NIBBLES-1][NIB_W-1]);
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    assign busy  = (state != ST_IDLE);
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed-vector scoreboard bench for mp_add_seq (NIBBLES=4); sub vectors follow MPADD_SUB_EN.
module tb_mp_add_seq;

    localparam int N = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   a;
    logic [15:0]   b;
    logic          c_in;
    logic          sub;
    logic          busy;
    logic          done;
    logic [15:0]   sum;
    logic          c_out;
    logic          ovf;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;

    mp_add_seq #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [15:0] es, input logic ec, input logic eo, input int ecyc);
        exp_t e;
        e.sum = es;
        e.c   = ec;
        e.o   = eo;
        e.cyc = ecyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && !done && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b pending=%0d", busy, sb.size());
            sb.delete();
        end
    endtask

    // Drive one operation from an idle negedge and queue its expected result.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic ts, input logic [15:0] es, input logic ec, input logic eo);
        a     = ta;
        b     = tb_v;
        c_in  = tc;
        sub   = ts;
        start = 1'b1;
        push(es, ec, eo, cyc + N + 2);
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_run", {31'd0, busy}, 32'd1);
        wait_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        c_in   = 1'b0;
        sub    = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: sum=%h cycle %0d", sum, cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("done_cycle", cyc, e.cyc);
                        chk("sum", {16'd0, sum}, {16'd0, e.sum});
                        chk("c_out", {31'd0, c_out}, {31'd0, e.c});
                        chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_c_out", {31'd0, c_out}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef MPADD_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`else
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0);
`endif

        // Result must hold after done while idle.
        repeat (3) @(negedge clk);
`ifdef MPADD_SUB_EN
        chk("sum_hold", {16'd0, sum}, 32'h0000_7FFF);
`else
        chk("sum_hold", {16'd0, sum}, 32'h0000_8001);
`endif

        // start held high: operand change mid-RUN feeds only the back-to-back second op.
        begin
            int e0;
            e0    = cyc;
            a     = 16'h1111;
            b     = 16'h2222;
            c_in  = 1'b0;
            sub   = 1'b0;
            start = 1'b1;
            push(16'h3333, 1'b0, 1'b0, e0 + N + 2);
            push(16'h1010, 1'b0, 1'b0, e0 + 2 * N + 4);
            @(negedge clk);
            a = 16'h0F0F;
            b = 16'h0101;
            chk("held_busy_run", {31'd0, busy}, 32'd1);
            repeat (N + 2) @(negedge clk);
            chk("held_second_accepted", {31'd0, busy}, 32'd1);
            start = 1'b0;
            wait_idle();
        end

        // Reset in the second RUN cycle aborts with no done pulse.
        a     = 16'h0F0F;
        b     = 16'h0F0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        chk("abort_c_out", {31'd0, c_out}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
